// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared constants and FSM state type for the HDC similarity search
package hdc_pkg;

    localparam int FRAME_W   = 64;
    localparam int N_FRAMES  = 3;
    localparam int N_CLASSES = 8;
    localparam int ID_W      = 3;
    localparam int IDX_W     = 2;
    localparam int DIST_W    = 8;

    typedef enum logic [1:0] {
        LOAD,
        SEARCH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/popcount_frame.sv
// rtl/popcount_frame.sv - combinational population count of one frame
module popcount_frame #(
    parameter int W     = 64,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     bits,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/class_sim_search.sv
// rtl/class_sim_search.sv - sequential nearest-class Hamming search over the class store
module class_sim_search
    import hdc_pkg::*;
#(
    parameter int FRAME_W   = hdc_pkg::FRAME_W,
    parameter int N_FRAMES  = hdc_pkg::N_FRAMES,
    parameter int N_CLASSES = hdc_pkg::N_CLASSES,
    parameter int ID_W      = hdc_pkg::ID_W,
    parameter int IDX_W     = hdc_pkg::IDX_W,
    parameter int DIST_W    = hdc_pkg::DIST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [FRAME_W-1:0] q_data,
    output logic [ID_W-1:0]    frame_id,
    output logic [IDX_W-1:0]   frame_index,
    input  logic [FRAME_W-1:0] class_vec_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_class,
    output logic [DIST_W-1:0]  res_dist
);

    localparam int PC_W = $clog2(FRAME_W + 1);
    localparam logic [IDX_W-1:0] LAST_FRM = IDX_W'(N_FRAMES - 1);
    localparam logic [ID_W-1:0]  LAST_CLS = ID_W'(N_CLASSES - 1);

    state_t state_q, state_d;

    logic [FRAME_W-1:0] query [N_FRAMES];
    logic [IDX_W-1:0]   ld_cnt;
    logic [IDX_W-1:0]   frm;
    logic [ID_W-1:0]    cls;
    logic               q_hs, last_issue;

    logic [PC_W-1:0]    pc_comb, pc_r;
    logic [ID_W-1:0]    cls_r;
    logic               s1_valid, first_r, last_r;

    logic [DIST_W-1:0]  acc, acc_sum, best_dist;
    logic [ID_W-1:0]    best_cls;

    assign q_ready     = (state_q == LOAD);
    assign res_valid   = (state_q == DONE);
    assign q_hs        = q_valid & q_ready;
    assign last_issue  = (cls == LAST_CLS) && (frm == LAST_FRM);
    assign frame_id    = (state_q == SEARCH) ? cls : '0;
    assign frame_index = (state_q == SEARCH) ? frm : '0;
    assign res_class   = best_cls;
    assign res_dist    = best_dist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (q_hs && ld_cnt == LAST_FRM) state_d = SEARCH;
            SEARCH:  if (last_issue) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (res_ready) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            for (int i = 0; i < N_FRAMES; i++) query[i] <= '0;
        end else if (q_hs) begin
            query[ld_cnt] <= q_data;
            ld_cnt        <= (ld_cnt == LAST_FRM) ? '0 : ld_cnt + 1'b1;
        end else if (res_valid && res_ready) begin
            ld_cnt <= '0;
        end
    end

    // frm wraps at N_FRAMES so the store never sees an out-of-range index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls <= '0;
            frm <= '0;
        end else if (state_q == SEARCH) begin
            if (frm == LAST_FRM) begin
                frm <= '0;
                cls <= cls + 1'b1;
            end else begin
                frm <= frm + 1'b1;
            end
        end else begin
            cls <= '0;
            frm <= '0;
        end
    end

    popcount_frame #(.W(FRAME_W), .CNT_W(PC_W)) u_popcount (
        .bits (query[frm] ^ class_vec_in),
        .cnt  (pc_comb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            pc_r     <= '0;
            cls_r    <= '0;
            first_r  <= 1'b0;
            last_r   <= 1'b0;
        end else begin
            s1_valid <= (state_q == SEARCH);
            pc_r     <= pc_comb;
            cls_r    <= cls;
            first_r  <= (frm == '0);
            last_r   <= (frm == LAST_FRM);
        end
    end

    assign acc_sum = (first_r ? '0 : acc) + DIST_W'(pc_r);

    // Strict less-than keeps the lower class id on ties since classes arrive in order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            best_dist <= '0;
            best_cls  <= '0;
        end else if (state_q == LOAD && state_d == SEARCH) begin
            acc       <= '0;
            best_dist <= '1;
            best_cls  <= '0;
        end else if (s1_valid) begin
            acc <= acc_sum;
            if (last_r && acc_sum < best_dist) begin
                best_dist <= acc_sum;
                best_cls  <= cls_r;
            end
        end
    end

endmodule
